ppu_zero_compressor: RTL and testbench
======================================

# ppu_zero_compressor

Downstream of the max-pooling stage in the PPU. Consumes pooled output vectors (per-lane valid mask plus data) and run-length encodes them into the SCNN sparse format: a stream of (nonzero value, preceding zero count) pairs per output channel. Results are buffered in an internal FIFO and drained through a valid/ready port toward the output-activation write-back.

## Interface
- LANES, 8, lanes per pooled vector (matches pooling_out_size)
- DATA_W, 16, signed activation width
- RUN_W, 4, zero-run field width; max run = 2^RUN_W-1
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)
- K_W, 6, channel index width

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- in_valid  in  LANES  per-lane valid of pooled vector; vector present when any bit is set
- in_data  in  LANES×DATA_W  pooled values
- in_k  in  K_W  channel index of the vector
- in_chan_last  in  1  vector is the last of channel in_k
- in_ready  out  1  vector accepted on clk edge when any in_valid bit and in_ready are both high
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_data  out  DATA_W  encoded value (0 for run-extension or terminator entries)
- out_run  out  RUN_W  zeros preceding out_data
- out_k  out  K_W  channel of entry
- out_last  out  1  channel terminator entry
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- FSM states: IDLE, SCAN, TERM.
- IDLE: in_ready=1. On accept, register in_valid, in_data, in_k, in_chan_last; lane_ptr←0; go to SCAN.
- SCAN: one lane per cycle, in ascending index order.
  - Lane with valid=0: skipped; lane_ptr advances; run unchanged.
  - Valid lane with value 0: if run < 2^RUN_W-1, run++. If run == max, emit (0, max) as run-extension and set run←1.
  - Valid nonzero lane: emit (value, run); run←0.
  - A SCAN cycle that must emit while the FIFO is full stalls: lane_ptr and run hold.
  - After the last lane: go to TERM if the registered chan_last is set, else go to IDLE. run carries across vectors of the same channel.
- TERM: emit (0, run, last=1); run←0; go to IDLE. Stalls while the FIFO is full.
- Every emitted entry carries the registered k.
- A channel with all-zero input produces only run-extension entries and the terminator.
- Data compare is a full DATA_W compare against zero. Only value 0 counts toward the run.

## Timing
- Reset values: out_valid=0, out_data=0, out_run=0, out_k=0, out_last=0, in_ready=0 while rst is high, busy=0, run=0, FIFO empty, state IDLE.
- in_ready is high in the first cycle after rst deasserts.
- Vector throughput: 1 accept cycle + LANES scan cycles (+1 TERM) with no FIFO stalls.
- FIFO: registered. An entry written at edge N is visible on out_valid after edge N.
- Simultaneous push and pop when full: the pop frees the slot only at that same edge. The push stalls in that cycle; there is no fall-through.
- Simultaneous push and pop when empty: out_valid goes high after the edge.
- out_* hold stable while out_valid & !out_ready.
- rst mid-operation: FSM, run and FIFO clear in one cycle, and in-flight entries are discarded.

## Configuration
- PPU_ZC_RELU_EN defined: each valid lane is clamped to 0 when negative (sign bit set) before the zero test. out_data is never negative.
- PPU_ZC_RELU_EN undefined: values pass unmodified. Negative values count as nonzero.

## Test plan
- Single vector, k=3, chan_last=1, valid=0xFF, data {0,0,5,0,0,0,7,0} -> entries (5,2),(7,3),(0,1,last); all with out_k=3; in_ready high again 10 cycles after accept.
- Two vectors of k=1, all lanes 0, chan_last only on the second (16 zeros, RUN_W=4) -> (0,15),(0,1,last).
- valid=0x0F, data lanes 0–3 = {0,9,0,0}, lanes 4–7 nonzero, chan_last=1 -> (9,1),(0,2,last); lanes 4–7 ignored.
- out_ready held 0, 12 nonzero lanes over 2 vectors (FIFO_DEPTH 8) -> 8 entries buffered, SCAN stalls, busy=1; release out_ready -> remaining entries emitted in order with none lost.
- Data {-4,0,…} with chan_last: macro defined -> (0,8,last) only; macro undefined -> (-4,0),(0,7,last).
- rst pulsed during SCAN with 3 entries queued -> next cycle out_valid=0, busy=0, in_ready=1; the next vector encodes with run starting at 0.

Source files
------------

// File: rtl/ppu_zero_compressor.sv
// Run-length encodes pooled PPU vectors into (value, preceding-zero-count) pairs per channel,
// buffered in an output FIFO. Define PPU_ZC_RELU_EN to clamp negative lanes to zero before encoding.
module ppu_zero_compressor #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RUN_W      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned K_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [K_W-1:0]          in_k,
    input  logic                    in_chan_last,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [RUN_W-1:0]        out_run,
    output logic [K_W-1:0]          out_k,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned LP_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RUN_MAX = (1 << RUN_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RUN_W-1:0]  run;
        logic [K_W-1:0]    k;
        logic              last;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SCAN, TERM} state_t;

    state_t              state_q, state_d;
    logic [LANES-1:0]    vld_q;
    logic [DATA_W-1:0]   data_q [LANES];
    logic [K_W-1:0]      k_q;
    logic                chan_last_q;
    logic [LP_W-1:0]     lane_q, lane_d;
    logic [RUN_W-1:0]    run_q, run_d;

    entry_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept_c;
    logic                fifo_full_c;
    logic                push_c;
    logic                pop_c;
    logic                advance_c;
    entry_t              push_entry_c;
    entry_t              head_c;
    logic [DATA_W-1:0]   lane_raw_c;
    logic [DATA_W-1:0]   lane_val_c;

    assign in_ready    = (state_q == IDLE) && !rst;
    assign accept_c    = (|in_valid) && in_ready;
    assign fifo_full_c = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign out_valid   = (cnt_q != '0);
    assign pop_c       = out_valid && out_ready;
    assign busy        = (state_q != IDLE) || (cnt_q != '0);

    assign lane_raw_c = data_q[lane_q];
`ifdef PPU_ZC_RELU_EN
    assign lane_val_c = lane_raw_c[DATA_W-1] ? '0 : lane_raw_c;
`else
    assign lane_val_c = lane_raw_c;
`endif

    // Next-state, run tracking and FIFO push request
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        run_d        = run_q;
        push_c       = 1'b0;
        advance_c    = 1'b0;
        push_entry_c = '0;
        push_entry_c.k = k_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SCAN;
                    lane_d  = '0;
                end
            end
            SCAN: begin
                if (!vld_q[lane_q]) begin
                    advance_c = 1'b1;
                end else if (lane_val_c == '0) begin
                    if (run_q != RUN_W'(RUN_MAX)) begin
                        run_d     = run_q + 1'b1;
                        advance_c = 1'b1;
                    end else if (!fifo_full_c) begin
                        // Saturated run: flush a run-extension entry, this zero starts the next run
                        push_c           = 1'b1;
                        push_entry_c.run = run_q;
                        run_d            = RUN_W'(1);
                        advance_c        = 1'b1;
                    end
                end else if (!fifo_full_c) begin
                    push_c            = 1'b1;
                    push_entry_c.data = lane_val_c;
                    push_entry_c.run  = run_q;
                    run_d             = '0;
                    advance_c         = 1'b1;
                end
                if (advance_c) begin
                    if (lane_q == LP_W'(LANES - 1)) begin
                        state_d = chan_last_q ? TERM : IDLE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            TERM: begin
                if (!fifo_full_c) begin
                    push_c            = 1'b1;
                    push_entry_c.run  = run_q;
                    push_entry_c.last = 1'b1;
                    run_d             = '0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, captured vector and run state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            k_q         <= '0;
            chan_last_q <= 1'b0;
            lane_q      <= '0;
            run_q       <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            run_q   <= run_d;
            if (accept_c) begin
                vld_q       <= in_valid;
                k_q         <= in_k;
                chan_last_q <= in_chan_last;
                for (int unsigned i = 0; i < LANES; i++) begin
                    data_q[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output FIFO; a push is never issued while full, so a same-edge pop cannot make room
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= push_entry_c;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    assign head_c   = mem_q[rd_ptr_q];
    assign out_data = head_c.data;
    assign out_run  = head_c.run;
    assign out_k    = head_c.k;
    assign out_last = head_c.last;

endmodule

// File: tb/tb_ppu_zero_compressor.sv
// Directed bench for ppu_zero_compressor: hand-computed RLE entries, stalls, reset and timing.
module tb_ppu_zero_compressor;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RUN_W  = 4;
    localparam int unsigned K_W    = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic [K_W-1:0]          in_k;
    logic                    in_chan_last;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [RUN_W-1:0]        out_run;
    logic [K_W-1:0]          out_k;
    logic                    out_last;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    ppu_zero_compressor dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_k         (in_k),
        .in_chan_last (in_chan_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_run      (out_run),
        .out_k        (out_k),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*DATA_W-1:0] pack8(input int a0, input int a1, input int a2,
                                                      input int a3, input int a4, input int a5,
                                                      input int a6, input int a7);
        logic [LANES*DATA_W-1:0] v;
        v = {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return v;
    endfunction

    task automatic send_vec(input logic [LANES-1:0] vld, input logic [LANES*DATA_W-1:0] d,
                            input logic [K_W-1:0] k, input logic last);
        int n = 0;
        in_valid     = vld;
        in_data      = d;
        in_k         = k;
        in_chan_last = last;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        step();
        in_valid = '0;
    endtask

    task automatic expect_entry(input string tag, input logic [DATA_W-1:0] d,
                                input logic [RUN_W-1:0] r, input logic [K_W-1:0] k,
                                input logic l);
        int n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        check($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s_data", tag), 32'(out_data), 32'(d));
        check($sformatf("%s_run", tag), 32'(out_run), 32'(r));
        check($sformatf("%s_k", tag), 32'(out_k), 32'(k));
        check($sformatf("%s_last", tag), 32'(out_last), 32'(l));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = '0;
        in_data      = '0;
        in_k         = '0;
        in_chan_last = 1'b0;
        out_ready    = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_run", 32'(out_run), 32'd0);
        check("rst_out_k", 32'(out_k), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single vector with timing: accept, 8 scan cycles, TERM, back in IDLE
        send_vec(8'hFF, pack8(0, 0, 5, 0, 0, 0, 7, 0), 6'd3, 1'b1);
        check("t1_ready_scan", 32'(in_ready), 32'd0);
        repeat (8) step();
        check("t1_ready_term", 32'(in_ready), 32'd0);
        step();
        check("t1_ready_idle", 32'(in_ready), 32'd1);
        check("t1_busy_fifo", 32'(busy), 32'd1);
        out_ready = 1'b1;
        expect_entry("t1_e0", 16'd5, 4'd2, 6'd3, 1'b0);
        expect_entry("t1_e1", 16'd7, 4'd3, 6'd3, 1'b0);
        expect_entry("t1_e2", 16'd0, 4'd1, 6'd3, 1'b1);
        check("t1_drained", 32'(out_valid), 32'd0);

        // 16 zeros over two vectors: saturated run then terminator
        send_vec(8'hFF, pack8(0, 0, 0, 0, 0, 0, 0, 0), 6'd1, 1'b0);
        send_vec(8'hFF, pack8(0, 0, 0, 0, 0, 0, 0, 0), 6'd1, 1'b1);
        expect_entry("t2_e0", 16'd0, 4'd15, 6'd1, 1'b0);
        expect_entry("t2_e1", 16'd0, 4'd1, 6'd1, 1'b1);

        // Partial valid mask: lanes 4-7 ignored
        send_vec(8'h0F, pack8(0, 9, 0, 0, 11, 12, 13, 14), 6'd2, 1'b1);
        expect_entry("t3_e0", 16'd9, 4'd1, 6'd2, 1'b0);
        expect_entry("t3_e1", 16'd0, 4'd2, 6'd2, 1'b1);

        // Negative lane
        send_vec(8'hFF, pack8(-4, 0, 0, 0, 0, 0, 0, 0), 6'd4, 1'b1);
`ifdef PPU_ZC_RELU_EN
        expect_entry("t5_e0", 16'd0, 4'd8, 6'd4, 1'b1);
`else
        expect_entry("t5_e0", 16'hFFFC, 4'd0, 6'd4, 1'b0);
        expect_entry("t5_e1", 16'd0, 4'd7, 6'd4, 1'b1);
`endif

        // Back-pressure: 12 nonzero lanes over two vectors into an 8-deep FIFO
        out_ready = 1'b0;
        send_vec(8'hFF, pack8(1, 2, 3, 4, 5, 6, 0, 0), 6'd5, 1'b0);
        send_vec(8'hFF, pack8(0, 0, 7, 8, 9, 10, 11, 12), 6'd5, 1'b1);
        repeat (12) step();
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd1);
        check("t4_head_hold", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            expect_entry($sformatf("t4_a%0d", i), 16'(i), 4'd0, 6'd5, 1'b0);
        end
        expect_entry("t4_b7", 16'd7, 4'd4, 6'd5, 1'b0);
        for (int i = 8; i <= 12; i++) begin
            expect_entry($sformatf("t4_b%0d", i), 16'(i), 4'd0, 6'd5, 1'b0);
        end
        expect_entry("t4_term", 16'd0, 4'd0, 6'd5, 1'b1);
        check("t4_drained", 32'(out_valid), 32'd0);

        // Reset during SCAN with three entries queued and a pending run of one
        out_ready = 1'b0;
        send_vec(8'hFF, pack8(1, 2, 3, 0, 0, 0, 0, 0), 6'd2, 1'b0);
        repeat (4) step();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_vec(8'h03, pack8(0, 4, 0, 0, 0, 0, 0, 0), 6'd7, 1'b1);
        expect_entry("t6_e0", 16'd4, 4'd1, 6'd7, 1'b0);
        expect_entry("t6_e1", 16'd0, 4'd0, 6'd7, 1'b1);
        check("end_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
